// File: rtl/clk_div_pkg.sv
// Shared types for the multi-channel clock divider: channel state encoding and minimum divisor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clk_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } chan_state_t;

    // Divisors below this value cannot form a period; a channel loaded with one parks in IDLE.
    localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, shadowed divisor, IDLE/RUN/STOP FSM, flop-driven output.
// Latency: RUN entered one edge after en is sampled; divisor updates land on period boundaries.
// Backpressure: none; div_wr is always accepted into the shadow (last write wins).
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int          WIDTH   = 16,
    parameter int unsigned RST_DIV = 40_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             div_wr,
    input  logic [WIDTH-1:0] div_val,
    input  logic             sync,
    output logic             clk_out,
    output logic             busy
`ifdef CLK_DIV_MULTI_TICK_EN
    ,output logic            tick
`endif
);

    localparam logic [WIDTH-1:0] RST_DIV_W = WIDTH'(RST_DIV);
    localparam logic [WIDTH-1:0] MIN_DIV_W = WIDTH'(MIN_DIV);
    localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);

    chan_state_t      state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cur_div_q, cur_div_d;
    logic [WIDTH-1:0] shd_div_q, shd_div_d;
    logic             pend_q, pend_d;
    logic             clk_out_q, clk_out_d;
    logic             boundary, restart, eff_pend;
    logic [WIDTH-1:0] eff_div;
`ifdef CLK_DIV_MULTI_TICK_EN
    logic             tick_q, tick_d;
`endif

    always_comb begin
        // A write landing in the boundary or sync cycle is visible to that same update.
        eff_pend  = pend_q | div_wr;
        eff_div   = div_wr ? div_val : shd_div_q;
        boundary  = (state_q != ST_IDLE) && (cnt_q == cur_div_q - ONE_W);
        restart   = (state_q == ST_RUN) && sync;

        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_div_d = cur_div_q;
        shd_div_d = eff_div;
        pend_d    = eff_pend;
`ifdef CLK_DIV_MULTI_TICK_EN
        tick_d    = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pend_q) begin
                    cur_div_d = shd_div_q;
                    pend_d    = div_wr;
                end else if (en && (cur_div_q >= MIN_DIV_W)) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (restart || boundary) begin
                    cnt_d = '0;
                    if (eff_pend) begin
                        cur_div_d = eff_div;
                        pend_d    = 1'b0;
                    end
`ifdef CLK_DIV_MULTI_TICK_EN
                    tick_d = boundary && !restart;
`endif
                    if (cur_div_d < MIN_DIV_W)
                        state_d = ST_IDLE;
                    else if (en)
                        state_d = ST_RUN;
                    else
                        state_d = restart ? ST_STOP : ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + ONE_W;
                    state_d = en ? ST_RUN : ST_STOP;
                end
            end
        endcase

        // Output is computed from next-cycle counter so the flop holds (cnt >= N>>1) exactly.
        clk_out_d = (state_d != ST_IDLE) && (cnt_d >= (cur_div_d >> 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cur_div_q <= RST_DIV_W;
            shd_div_q <= RST_DIV_W;
            pend_q    <= 1'b0;
            clk_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_div_q <= cur_div_d;
            shd_div_q <= shd_div_d;
            pend_q    <= pend_d;
            clk_out_q <= clk_out_d;
        end
    end

`ifdef CLK_DIV_MULTI_TICK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tick_q <= 1'b0;
        else
            tick_q <= tick_d;
    end

    assign tick = tick_q;
`endif

    assign clk_out = clk_out_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: rtl/clk_div_multi.sv
// CHANNELS independent glitch-free clock dividers with shared sync; tick port only with CLK_DIV_MULTI_TICK_EN.
// Latency: per channel, one edge from en to RUN; outputs are flop-driven.
// Backpressure: none; writes and sync are accepted every cycle.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int          WIDTH    = 16,
    parameter int          CHANNELS = 2,
    parameter int unsigned RST_DIV  = 40_000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       div_wr,
    input  logic [CHANNELS*WIDTH-1:0] div_val,
    input  logic                      sync,
    output logic [CHANNELS-1:0]       clk_out,
    output logic [CHANNELS-1:0]       busy
`ifdef CLK_DIV_MULTI_TICK_EN
    ,output logic [CHANNELS-1:0]      tick
`endif
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        clk_div_chan #(
            .WIDTH   (WIDTH),
            .RST_DIV (RST_DIV)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en[i]),
            .div_wr  (div_wr[i]),
            .div_val (div_val[i*WIDTH +: WIDTH]),
            .sync    (sync),
            .clk_out (clk_out[i]),
            .busy    (busy[i])
`ifdef CLK_DIV_MULTI_TICK_EN
            ,.tick   (tick[i])
`endif
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: default divide, shadowed writes, stop/resume, sync, N<2 and reset.
module tb_clk_div_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  en;
    logic [1:0]  div_wr;
    logic [31:0] div_val;
    logic        sync;
    logic [1:0]  clk_out;
    logic [1:0]  busy;
`ifdef CLK_DIV_MULTI_TICK_EN
    logic [1:0]  tick;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n;

    always #5 clk = ~clk;

    clk_div_multi #(.WIDTH(16), .CHANNELS(2), .RST_DIV(40_000)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .div_wr  (div_wr),
        .div_val (div_val),
        .sync    (sync),
        .clk_out (clk_out),
        .busy    (busy)
`ifdef CLK_DIV_MULTI_TICK_EN
        ,.tick   (tick)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Counts edges until clk_out[ch] equals val; gives up after budget edges.
    task automatic edges_until(input int ch, input logic val, input int budget, output int cnt);
        cnt = 0;
        do begin
            step(1);
            cnt++;
        end while (clk_out[ch] !== val && cnt < budget);
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 2'b00;
        div_wr  = 2'b00;
        div_val = '0;
        sync    = 1'b0;
        #12;
        check("reset clk_out", 32'(clk_out), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
`ifdef CLK_DIV_MULTI_TICK_EN
        check("reset tick", 32'(tick), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(2);

        // Default divisor 40000 on ch0; queue N=4 during the high phase.
        en[0] = 1'b1;
        step(1);
        check("start busy", 32'(busy[0]), 32'd1);
        check("start clk_out", 32'(clk_out[0]), 32'd0);
        edges_until(0, 1'b1, 30000, n);
        check("default low", 32'(n), 32'd20000);
        div_wr  = 2'b01;
        div_val = 32'd4;
        step(1);
        div_wr = 2'b00;
        edges_until(0, 1'b0, 30000, n);
        check("default high rest", 32'(n), 32'd19999);

        // ch0 now at N=4, cnt=0: two writes before the boundary, last (6) wins.
        div_wr  = 2'b01;
        div_val = 32'd9;
        step(1);
        div_val = 32'd6;
        step(1);
        div_wr = 2'b00;
        check("n4 high mid", 32'(clk_out[0]), 32'd1);
        edges_until(0, 1'b0, 20, n);
        check("n4 period end", 32'(n), 32'd2);
        edges_until(0, 1'b1, 20, n);
        check("n6 low", 32'(n), 32'd3);
        edges_until(0, 1'b0, 20, n);
        check("n6 high", 32'(n), 32'd3);

        // ch1 N=5 written in IDLE, then started.
        div_wr  = 2'b10;
        div_val = 32'd5 << 16;
        step(1);
        div_wr = 2'b00;
        step(1);
        en[1] = 1'b1;
        edges_until(1, 1'b1, 20, n);
        check("n5 first rise", 32'(n), 32'd3);
        edges_until(1, 1'b0, 20, n);
        check("n5 high", 32'(n), 32'd3);
        edges_until(1, 1'b1, 20, n);
        check("n5 low", 32'(n), 32'd2);
`ifdef CLK_DIV_MULTI_TICK_EN
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (tick[1] === 1'b1) n++;
        end
        check("n5 ticks in 10", 32'(n), 32'd2);
`endif

        // ch1 N=8 applied on sync restart; drop en at cnt=1.
        div_wr  = 2'b10;
        div_val = 32'd8 << 16;
        sync    = 1'b1;
        step(1);
        div_wr = 2'b00;
        sync   = 1'b0;
        check("sync restart", 32'(clk_out), 32'd0);
        step(1);
        en[1] = 1'b0;
        step(6);
        check("stop last cycle busy", 32'(busy[1]), 32'd1);
        check("stop last cycle clk", 32'(clk_out[1]), 32'd1);
        step(1);
        check("stop busy fall", 32'(busy[1]), 32'd0);
        check("stop clk low", 32'(clk_out[1]), 32'd0);

        // Re-raise en at cnt=5 while stopping: no gap.
        en[1] = 1'b1;
        step(2);
        en[1] = 1'b0;
        step(4);
        check("stop state busy", 32'(busy[1]), 32'd1);
        en[1] = 1'b1;
        step(2);
        check("resume high", 32'(clk_out[1]), 32'd1);
        step(1);
        check("resume wrap clk", 32'(clk_out[1]), 32'd0);
        check("resume wrap busy", 32'(busy[1]), 32'd1);
        edges_until(1, 1'b1, 20, n);
        check("resume low", 32'(n), 32'd4);

        // ch0 N=4, ch1 N=6 applied together with sync; stay aligned.
        div_wr  = 2'b11;
        div_val = (32'd6 << 16) | 32'd4;
        sync    = 1'b1;
        step(1);
        div_wr = 2'b00;
        sync   = 1'b0;
        check("align clk_out", 32'(clk_out), 32'd0);
        check("align busy", 32'(busy), 32'd3);
        for (int i = 1; i <= 24; i++) begin
            logic [1:0] exp_out;
            step(1);
            exp_out[0] = ((i % 4) >= 2);
            exp_out[1] = ((i % 6) >= 3);
            check($sformatf("align cyc %0d", i), 32'(clk_out), 32'(exp_out));
        end

        // N=1 on ch1 parks it in IDLE at the boundary even with en high.
        div_wr  = 2'b10;
        div_val = 32'd1 << 16;
        step(1);
        div_wr = 2'b00;
        step(4);
        check("n1 before boundary", 32'(busy[1]), 32'd1);
        step(1);
        check("n1 idle busy", 32'(busy[1]), 32'd0);
        check("n1 idle clk", 32'(clk_out[1]), 32'd0);
        step(10);
        check("n1 stays idle", 32'(busy[1]), 32'd0);
        check("n1 stays low", 32'(clk_out[1]), 32'd0);

        // Asynchronous reset during ch0 high phase.
        edges_until(0, 1'b1, 10, n);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst clk_out", 32'(clk_out), 32'd0);
        check("arst busy", 32'(busy), 32'd0);
        en = 2'b01;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        edges_until(0, 1'b1, 30000, n);
        check("post reset default low", 32'(n), 32'd20001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
